// File: rtl/hplvds_rx_pkg.sv
// Shared types and constants for the HPLVDS receiver pad controller.
package hplvds_rx_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_IDLE   = 2'd3
    } rx_state_t;

    localparam int TRIM_W     = 4;
    localparam int GAIN_W     = 3;
    localparam int CTLE_RES_W = 7;
    localparam int CTLE_CAP_W = 3;
    localparam int CFG_W      = 1 + GAIN_W + CTLE_RES_W + CTLE_CAP_W + TRIM_W;

    typedef struct packed {
        logic                  pol;
        logic [GAIN_W-1:0]     gain;
        logic [CTLE_RES_W-1:0] ctle_res;
        logic [CTLE_CAP_W-1:0] ctle_cap;
        logic [TRIM_W-1:0]     rterm_trim;
    } rx_cfg_t;

    localparam rx_cfg_t CFG_DEFAULT = '0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hplvds_sync2.sv
// Two-flop synchronizer for asynchronous pad signals, clears to 0 on reset.
module hplvds_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/hplvds_rx_ctrl.sv
// HPLVDS receiver pad controller: power-up sequencing, shadow config
// registers and electrical-idle debounce into a link IDLE state.
module hplvds_rx_ctrl
    import hplvds_rx_pkg::*;
#(
    parameter int SETTLE_CYC = 64,
    parameter int EI_FILT    = 8,
    parameter int EXIT_FILT  = 4
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  EN_I,
    input  logic                  AC_COUPLED_I,
    input  logic                  CFG_VALID_I,
    output logic                  CFG_READY_O,
    input  logic [CFG_W-1:0]      CFG_DATA_I,
    input  logic                  DI_I,
    input  logic                  EI_DETECT_I,
    output logic                  RTERM_EN_O,
    output logic                  RX_EN_O,
    output logic                  RX_VCM_EN_O,
    output logic                  EI_DETECT_EN_O,
    output logic                  RX_POL_O,
    output logic [TRIM_W-1:0]     RTERM_TRIM_O,
    output logic [3:1]            RX_GAIN_O,
    output logic [7:1]            RX_CTLE_RES_O,
    output logic [3:1]            RX_CTLE_CAP_O,
    output logic                  DATA_O,
    output logic                  DATA_VALID_O,
    output logic                  IDLE_O,
    output logic                  READY_O
);

    localparam int CNT_TOP = max3(SETTLE_CYC, EI_FILT, EXIT_FILT);
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] CNT_MAX     = CW'(CNT_TOP);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] EI_LAST     = CW'(EI_FILT - 1);
    localparam logic [CW-1:0] EXIT_LAST   = CW'(EXIT_FILT - 1);

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ei_sync, di_sync;
    logic          cfg_ready, cfg_fire;
    logic          rx_on_n;
    rx_cfg_t       shadow;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    hplvds_sync2 u_sync_di (.clk(CLK_I), .rst(RST_I), .d(DI_I),        .q(di_sync));
    hplvds_sync2 u_sync_ei (.clk(CLK_I), .rst(RST_I), .d(EI_DETECT_I), .q(ei_sync));

    // Held low while reset is asserted so no config can be offered into a clearing block.
    assign cfg_ready   = !RST_I && ((state == ST_OFF) || ((state == ST_IDLE) && EN_I));
    assign cfg_fire    = CFG_VALID_I && cfg_ready;
    assign CFG_READY_O = cfg_ready;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_OFF: begin
                if (EN_I) state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) state_n = ST_ACTIVE;
                else                    cnt_n   = sat_inc(cnt);
            end
            ST_ACTIVE: begin
                if (!ei_sync)           cnt_n   = '0;
                else if (cnt == EI_LAST) state_n = ST_IDLE;
                else                    cnt_n   = sat_inc(cnt);
            end
            ST_IDLE: begin
                if (cfg_fire)             state_n = ST_SETTLE;
                else if (ei_sync)         cnt_n   = '0;
                else if (cnt == EXIT_LAST) state_n = ST_ACTIVE;
                else                      cnt_n   = sat_inc(cnt);
            end
            default: state_n = ST_OFF;
        endcase
        // Disable overrides every other event; every state entry restarts the count.
        if (!EN_I) state_n = ST_OFF;
        if (state_n != state) cnt_n = '0;
    end

    assign rx_on_n = (state_n == ST_ACTIVE) || (state_n == ST_IDLE);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            RTERM_EN_O     <= 1'b0;
            RX_EN_O        <= 1'b0;
            RX_VCM_EN_O    <= 1'b0;
            EI_DETECT_EN_O <= 1'b0;
            DATA_O         <= 1'b0;
            DATA_VALID_O   <= 1'b0;
            IDLE_O         <= 1'b0;
            READY_O        <= 1'b0;
        end else begin
            RTERM_EN_O     <= (state_n != ST_OFF);
            RX_EN_O        <= rx_on_n;
            RX_VCM_EN_O    <= (state_n != ST_OFF) && AC_COUPLED_I;
            EI_DETECT_EN_O <= rx_on_n;
            DATA_O         <= (state_n == ST_ACTIVE) && di_sync;
            DATA_VALID_O   <= (state_n == ST_ACTIVE);
            IDLE_O         <= (state_n == ST_IDLE);
            READY_O        <= rx_on_n;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)         shadow <= CFG_DEFAULT;
        else if (cfg_fire) shadow <= rx_cfg_t'(CFG_DATA_I);
    end

    assign RX_POL_O      = shadow.pol;
    assign RX_GAIN_O     = shadow.gain;
    assign RX_CTLE_RES_O = shadow.ctle_res;
    assign RX_CTLE_CAP_O = shadow.ctle_cap;
    assign RTERM_TRIM_O  = shadow.rterm_trim;

endmodule

// File: tb/tb_hplvds_rx_ctrl.sv
// Bench for hplvds_rx_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the link states.
module tb_hplvds_rx_ctrl;

    localparam int SETTLE_CYC = 64;
    localparam int EI_FILT    = 8;
    localparam int EXIT_FILT  = 4;

    localparam int M_OFF = 0, M_SETTLE = 1, M_ACTIVE = 2, M_IDLE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, ac = 1'b0, cfg_valid = 1'b0, di = 1'b0, ei = 1'b0;
    logic [17:0] cfg_data = '0;
    logic        cfg_ready, rterm_en, rx_en, vcm_en, ei_en, pol;
    logic [3:0]  trim;
    logic [3:1]  gain;
    logic [7:1]  ctle_res;
    logic [3:1]  ctle_cap;
    logic        data, data_valid, idle, ready;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int          m_state = M_OFF;
    int          m_enter = 0;
    int          edge_n = 0;
    int          run1 = 0, run0 = 0;
    logic [17:0] m_shadow = '0;
    logic        m_ac = 1'b0, m_data = 1'b0;
    bit          ei_q[$];
    bit          di_q[$];

    hplvds_rx_ctrl #(.SETTLE_CYC(SETTLE_CYC), .EI_FILT(EI_FILT), .EXIT_FILT(EXIT_FILT)) dut (
        .CLK_I(clk), .RST_I(rst), .EN_I(en), .AC_COUPLED_I(ac),
        .CFG_VALID_I(cfg_valid), .CFG_READY_O(cfg_ready), .CFG_DATA_I(cfg_data),
        .DI_I(di), .EI_DETECT_I(ei),
        .RTERM_EN_O(rterm_en), .RX_EN_O(rx_en), .RX_VCM_EN_O(vcm_en),
        .EI_DETECT_EN_O(ei_en), .RX_POL_O(pol),
        .RTERM_TRIM_O(trim), .RX_GAIN_O(gain), .RX_CTLE_RES_O(ctle_res),
        .RX_CTLE_CAP_O(ctle_cap),
        .DATA_O(data), .DATA_VALID_O(data_valid), .IDLE_O(idle), .READY_O(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [26:0] dut_outs();
        return {rterm_en, rx_en, vcm_en, ei_en, pol, trim, gain, ctle_res, ctle_cap,
                data, data_valid, idle, ready, cfg_ready};
    endfunction

    function automatic logic [26:0] exp_outs();
        logic on, pw, rdy;
        if (rst) return '0;
        pw  = (m_state != M_OFF);
        on  = (m_state == M_ACTIVE) || (m_state == M_IDLE);
        rdy = (m_state == M_OFF) || ((m_state == M_IDLE) && en);
        // config word fields: pol[17] gain[16:14] res[13:7] cap[6:4] trim[3:0]
        return {pw, on, pw & m_ac, on, m_shadow[17], m_shadow[3:0], m_shadow[16:14],
                m_shadow[13:7], m_shadow[6:4], m_data, m_state == M_ACTIVE,
                m_state == M_IDLE, on, rdy};
    endfunction

    task automatic model_step();
        bit ei_s, di_s, rdy, fire;
        int ns;
        edge_n++;
        ei_q.push_back(ei);
        di_q.push_back(di);
        if (ei_q.size() > 3) void'(ei_q.pop_front());
        if (di_q.size() > 3) void'(di_q.pop_front());
        // the controller sees the pad value sampled two edges earlier
        ei_s = (ei_q.size() == 3) ? ei_q[0] : 1'b0;
        di_s = (di_q.size() == 3) ? di_q[0] : 1'b0;
        rdy  = (m_state == M_OFF) || ((m_state == M_IDLE) && en);
        fire = cfg_valid && rdy;
        ns   = m_state;
        if (!en) ns = M_OFF;
        else begin
            case (m_state)
                M_OFF:    ns = M_SETTLE;
                M_SETTLE: if (edge_n - m_enter == SETTLE_CYC) ns = M_ACTIVE;
                M_ACTIVE: begin
                    run1 = ei_s ? run1 + 1 : 0;
                    if (run1 >= EI_FILT) ns = M_IDLE;
                end
                default: begin
                    if (fire) ns = M_SETTLE;
                    else begin
                        run0 = ei_s ? 0 : run0 + 1;
                        if (run0 >= EXIT_FILT) ns = M_ACTIVE;
                    end
                end
            endcase
        end
        if (fire) m_shadow = cfg_data;
        if (ns != m_state) begin
            m_enter = edge_n;
            run1 = 0;
            run0 = 0;
        end
        m_state = ns;
        m_ac    = ac;
        m_data  = (ns == M_ACTIVE) ? di_s : 1'b0;
    endtask

    task automatic model_reset();
        m_state  = M_OFF;
        m_shadow = '0;
        m_ac     = 1'b0;
        m_data   = 1'b0;
        run1     = 0;
        run0     = 0;
        ei_q.delete();
        di_q.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("outs", 32'(dut_outs()), 32'(exp_outs()));
        di = 1'($urandom_range(0, 1));
    endtask

    // called 1 time unit after a rising edge; finishes before the next one
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_outs", 32'(dut_outs()), 32'h0);
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("post_rst", 32'(dut_outs()), 32'(exp_outs()));
        chk("post_rst_cfg_ready", 32'(cfg_ready), 32'h1);
    endtask

    task automatic count_until(input int which, input bit level, output int n);
        n = 0;
        while (n < 200) begin
            if ((which == 0 && rx_en == level) || (which == 1 && idle == level)) break;
            cyc();
            n++;
        end
        if (n >= 200) chk("wait_timeout", 32'(n), 32'(199));
    endtask

    initial begin
        int n;
        int seen;
        int ei_hold;
        @(posedge clk);
        #1;
        pulse_reset();

        // power-up with EN rising at edge 10
        ac = 1'b1;
        repeat (9) cyc();
        en = 1'b1;
        cyc();
        chk("rterm_after_en", 32'(rterm_en), 32'h1);
        chk("vcm_after_en", 32'(vcm_en), 32'h1);
        chk("rx_en_in_settle", 32'(rx_en), 32'h0);
        chk("data_in_settle", 32'(data), 32'h0);
        count_until(0, 1'b1, n);
        chk("settle_len", 32'(n), 32'(SETTLE_CYC));
        chk("ready_active", 32'(ready), 32'h1);
        chk("valid_active", 32'(data_valid), 32'h1);

        // EI one sample short of the filter must not reach IDLE
        seen = 0;
        ei = 1'b1;
        repeat (EI_FILT - 1) begin cyc(); seen |= int'(idle); end
        ei = 1'b0;
        repeat (10) begin cyc(); seen |= int'(idle); end
        chk("short_ei_no_idle", 32'(seen), 32'h0);

        ei = 1'b1;
        cyc();
        count_until(1, 1'b1, n);
        chk("idle_entry_lat", 32'(n), 32'(EI_FILT + 1));
        ei = 1'b0;
        cyc();
        count_until(1, 1'b0, n);
        chk("idle_exit_lat", 32'(n), 32'(EXIT_FILT + 1));
        chk("back_active", 32'(data_valid), 32'h1);

        // config offered in ACTIVE waits until IDLE, then forces a resettle
        cfg_valid = 1'b1;
        cfg_data  = 18'h2A5C3;
        #1;
        chk("cfg_ready_active", 32'(cfg_ready), 32'h0);
        ei = 1'b1;
        n = 0;
        while (trim != 4'h3 && n < 60) begin cyc(); n++; end
        cfg_valid = 1'b0;
        ei = 1'b0;
        chk("cfg_trim", 32'(trim), 32'h3);
        chk("cfg_rx_en_drop", 32'(rx_en), 32'h0);
        chk("cfg_pol", 32'(pol), 32'h1);
        count_until(0, 1'b1, n);
        chk("resettle_len", 32'(n), 32'(SETTLE_CYC));

        // EN falling together with a config offer in IDLE: disable wins, nothing loads
        ei = 1'b1;
        cyc();
        count_until(1, 1'b1, n);
        en = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 18'h15A3C;
        cyc();
        cfg_valid = 1'b0;
        ei = 1'b0;
        chk("en_drop_trim_kept", 32'(trim), 32'h3);
        chk("en_drop_rterm", 32'(rterm_en), 32'h0);
        chk("en_drop_rx_en", 32'(rx_en), 32'h0);
        chk("en_drop_idle", 32'(idle), 32'h0);

        // reset in the middle of a settle interval
        en = 1'b1;
        repeat (31) cyc();
        pulse_reset();
        cyc();
        chk("settle_after_rst", 32'(rterm_en), 32'h1);
        count_until(0, 1'b1, n);
        chk("full_settle_after_rst", 32'(n), 32'(SETTLE_CYC));

        // random traffic
        ei_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (ei_hold == 0) begin
                ei = 1'($urandom_range(0, 1));
                ei_hold = $urandom_range(1, 12);
            end
            ei_hold--;
            en        = ($urandom_range(0, 299) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_data  = 18'($urandom);
            if ($urandom_range(0, 49) == 0) ac = ~ac;
            cyc();
            if ($urandom_range(0, 699) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
